// File: rtl/series_controller.sv
// series_controller: Moore FSM sequencing the term/exp series datapath.
// Ports:
//   clk, rst (async, active-low), start, y[7:0]   -> request and term count
//   ready, done                                   -> handshake
//   ldx, ldy, init_term, init_exp, ldterm, ldexp  -> register load strobes
//   minus1_en, x_en, i_en, iplus_en               -> multiplier operand select
//   counteri, counteriplus [CW-1:0]               -> reciprocal ROM addresses
module series_controller #(
  parameter int CW       = 4,
  parameter int MAX_ITER = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    y,
  output logic          ready,
  output logic          done,
  output logic          ldx,
  output logic          ldy,
  output logic          init_term,
  output logic          init_exp,
  output logic          ldterm,
  output logic          ldexp,
  output logic          minus1_en,
  output logic          x_en,
  output logic          i_en,
  output logic          iplus_en,
  output logic [CW-1:0] counteri,
  output logic [CW-1:0] counteriplus
);
  localparam int NW = $clog2(MAX_ITER + 1);
  typedef enum logic [3:0] {IDLE, LOAD, NEG, MX1, MX2, DI, DIP, ACC, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnti_q, cnti_d;
  logic [NW-1:0] iter_q, iter_d;
  logic [NW-1:0] n;
  logic [7:0]    ym1;
  // x is term 1, so y terms need y-1 iterations, capped to keep ROM addresses in range
  assign ym1 = y - 8'd1;
  assign n   = (y <= 8'd1) ? '0 : (ym1 > 8'(MAX_ITER)) ? NW'(MAX_ITER) : ym1[NW-1:0];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnti_q  <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      cnti_q  <= cnti_d;
      iter_q  <= iter_d;
    end
  end
  always_comb begin
    state_d = IDLE;
    cnti_d  = cnti_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: state_d = start ? LOAD : IDLE;
      LOAD: begin
        cnti_d  = CW'(2);
        iter_d  = n;
        state_d = (n == '0) ? DONE : NEG;
      end
      NEG:  state_d = MX1;
      MX1:  state_d = MX2;
      MX2:  state_d = DI;
      DI:   state_d = DIP;
      DIP:  state_d = ACC;
      ACC: begin
        iter_d  = iter_q - NW'(1);
        cnti_d  = cnti_q + CW'(2);
        state_d = (iter_q == NW'(1)) ? DONE : NEG;
      end
      default: state_d = IDLE;
    endcase
  end
  assign ready        = state_q == IDLE;
  assign done         = state_q == DONE;
  assign ldx          = state_q == LOAD;
  assign ldy          = state_q == LOAD;
  assign init_term    = state_q == LOAD;
  assign init_exp     = state_q == LOAD;
  assign ldterm       = state_q inside {LOAD, NEG, MX1, MX2, DI, DIP};
  assign ldexp        = state_q inside {LOAD, ACC};
  assign minus1_en    = state_q == NEG;
  assign x_en         = state_q inside {MX1, MX2};
  assign i_en         = state_q == DI;
  assign iplus_en     = state_q == DIP;
  assign counteri     = cnti_q;
  assign counteriplus = cnti_q + CW'(1);
endmodule
